// File: rtl/processor_n_pkg.sv
// processor_n_pkg: opcodes, FSM encoding and control-word field layout shared by the datapath
package processor_n_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_PASS = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL = 2'd2;
  localparam logic [1:0] S_WB = 2'd3;
  localparam int F_A_SRC = 0;
  localparam int F_A_REG = 1;
  function automatic int f_b_src(input int rw);
    return 1 + rw;
  endfunction
  function automatic int f_b_reg(input int rw);
    return 2 + rw;
  endfunction
  function automatic int f_op(input int rw);
    return 2 + 2 * rw;
  endfunction
  function automatic int f_cin(input int rw);
    return 6 + 2 * rw;
  endfunction
  function automatic int f_dest_en(input int rw);
    return 7 + 2 * rw;
  endfunction
  function automatic int f_dest_reg(input int rw);
    return 8 + 2 * rw;
  endfunction
  function automatic int f_f_en(input int rw);
    return 8 + 3 * rw;
  endfunction
  function automatic int ctrl_w(input int rw);
    return 9 + 3 * rw;
  endfunction
endpackage

// File: rtl/processor_n_alu.sv
// alu_n: single-cycle combinational ALU for ops 0-7; any other code yields zero with clear flags
module alu_n
  import processor_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             c4,
  output logic             c8,
  output logic             v
);
  localparam int H = WIDTH / 2;
  logic [WIDTH-1:0] bb;
  logic [WIDTH:0] sum;
  always_comb begin
    bb = op == OP_SUB ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(cin);
    res = '0;
    c4 = 1'b0;
    c8 = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res = sum[WIDTH-1:0];
        // carry into bit H equals the carry out of the low half
        c4 = a[H] ^ bb[H] ^ sum[H];
        c8 = sum[WIDTH];
        v = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR: res = a | b;
      OP_XOR: res = a ^ b;
      OP_PASS: res = a;
      OP_SHL: begin
        res = {a[WIDTH-2:0], cin};
        c8 = a[WIDTH-1];
        v = a[WIDTH-1] ^ a[WIDTH-2];
      end
      OP_SHR: begin
        res = {cin, a[WIDTH-1:1]};
        c8 = a[0];
      end
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/processor_n.sv
// processor_n: A/B input regs, temp register file, registered F/flags, handshaked ALU and shift-add multiply
module processor_n
  import processor_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG = 4,
  localparam int RW = $clog2(NREG),
  localparam int CW = ctrl_w(RW)
) (
  input  logic             SYSTEM_CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_IN_A,
  input  logic [WIDTH-1:0] DATA_IN_B,
  input  logic             LOAD_IN,
  input  logic             CTRL_VALID,
  output logic             CTRL_READY,
  input  logic [CW-1:0]    CTRL_WORD,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic [4:0]       STATUS_BITS,
  output logic             DONE
);
  localparam int NW = $clog2(WIDTH) + 1;
  localparam int BS = f_b_src(RW);
  localparam int BR = f_b_reg(RW);
  localparam int OPF = f_op(RW);
  localparam int CI = f_cin(RW);
  localparam int DE = f_dest_en(RW);
  localparam int DR = f_dest_reg(RW);
  localparam int FE = f_f_en(RW);
  logic [1:0] state;
  logic [WIDTH-1:0] in_a, in_b, a_q, b_q, f, a_sel, b_sel, alu_res, res;
  logic [WIDTH-1:0] tmp [NREG];
  logic [3:0] op_q;
  logic [RW-1:0] dr_q;
  logic cin_q, de_q, fe_q, c4, c8, z, v, done, wb, mul_hi, alu_c4, alu_c8, alu_v;
  logic [2*WIDTH-1:0] acc, mc;
  logic [NW-1:0] cnt;
  alu_n #(.WIDTH(WIDTH)) u_alu (
    .a(a_q),
    .b(b_q),
    .op(op_q),
    .cin(cin_q),
    .res(alu_res),
    .c4(alu_c4),
    .c8(alu_c8),
    .v(alu_v)
  );
  always_comb begin
    a_sel = CTRL_WORD[F_A_SRC] ? tmp[CTRL_WORD[F_A_REG +: RW]] : in_a;
    b_sel = CTRL_WORD[BS] ? tmp[CTRL_WORD[BR +: RW]] : in_b;
    wb = state == S_EXEC || state == S_WB;
    mul_hi = |acc[2*WIDTH-1:WIDTH];
    res = state == S_WB ? acc[WIDTH-1:0] : alu_res;
  end
  assign CTRL_READY = state == S_IDLE && !RESET;
  assign DATA_OUT = f;
  assign STATUS_BITS = {v, f == '0, z, c8, c4};
  assign DONE = done;
  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      in_a <= '0;
      in_b <= '0;
      f <= '0;
      c4 <= 1'b0;
      c8 <= 1'b0;
      z <= 1'b0;
      v <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < NREG; i++) tmp[i] <= '0;
    end else begin
      if (LOAD_IN) begin
        in_a <= DATA_IN_A;
        in_b <= DATA_IN_B;
      end
      done <= wb;
      if (wb) begin
        if (de_q) tmp[dr_q] <= res;
        if (fe_q) f <= res;
        c4 <= state == S_WB ? 1'b0 : alu_c4;
        c8 <= state == S_WB ? mul_hi : alu_c8;
        v <= state == S_WB ? mul_hi : alu_v;
        z <= res == '0;
      end
      case (state)
        S_IDLE: if (CTRL_VALID) begin
          a_q <= a_sel;
          b_q <= b_sel;
          op_q <= CTRL_WORD[OPF +: 4];
          cin_q <= CTRL_WORD[CI];
          de_q <= CTRL_WORD[DE];
          dr_q <= CTRL_WORD[DR +: RW];
          fe_q <= CTRL_WORD[FE];
          acc <= '0;
          mc <= {{WIDTH{1'b0}}, a_sel};
          cnt <= '0;
          state <= CTRL_WORD[OPF +: 4] == OP_MUL ? S_MUL : S_EXEC;
        end
        // multiplier bits are consumed LSB-first from b_q while the multiplicand walks left
        S_MUL: begin
          acc <= acc + (b_q[0] ? mc : '0);
          mc <= mc << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + NW'(1);
          if (cnt == NW'(WIDTH - 1)) state <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_processor_n.sv
// tb_processor_n: directed and randomized bench checked every cycle against an op-level reference model
module tb_processor_n;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, valid = 1'b0;
  logic ready, done;
  logic [7:0] din_a = '0, din_b = '0, dout;
  logic [14:0] word = '0, w;
  logic [4:0] status;
  int ncmp = 0, nbad = 0;
  int m_a, m_b, m_f, m_c4, m_c8, m_z, m_v, m_done, m_left;
  int m_tmp [4];
  int p_res, p_c4, p_c8, p_v, p_de, p_dr, p_fe, x_op, x_a, x_b;
  bit m_busy = 0, armed = 0;

  processor_n #(.WIDTH(8), .NREG(4)) dut (
    .SYSTEM_CLK(clk),
    .RESET(rst),
    .DATA_IN_A(din_a),
    .DATA_IN_B(din_b),
    .LOAD_IN(load),
    .CTRL_VALID(valid),
    .CTRL_READY(ready),
    .CTRL_WORD(word),
    .DATA_OUT(dout),
    .STATUS_BITS(status),
    .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // result and flags straight from the arithmetic definition of each opcode
  function automatic void ref_op(input int op, input int a, input int b, input int cin,
                                 output int r, output int c4, output int c8, output int v);
    int s, sa, sb;
    r = 0; c4 = 0; c8 = 0; v = 0;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    case (op)
      0: begin
        s = a + b + cin; r = s % 256; c8 = s / 256;
        c4 = ((a % 16) + (b % 16) + cin) / 16;
        s = sa + sb + cin; v = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        s = a + (255 - b) + cin; r = s % 256; c8 = s / 256;
        c4 = ((a % 16) + (15 - b % 16) + cin) / 16;
        s = sa - sb - 1 + cin; v = (s > 127 || s < -128) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      6: begin r = (a * 2 + cin) % 256; c8 = a / 128; v = (a / 128 != r / 128) ? 1 : 0; end
      7: begin r = cin * 128 + a / 2; c8 = a % 2; end
      8: begin s = a * b; r = s % 256; c8 = s > 255 ? 1 : 0; v = c8; end
      default: r = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_a = 0; m_b = 0; m_f = 0; m_c4 = 0; m_c8 = 0; m_z = 0; m_v = 0; m_done = 0;
      foreach (m_tmp[i]) m_tmp[i] = 0;
      m_busy = 0; armed = 1;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          if (p_de != 0) m_tmp[p_dr] = p_res;
          if (p_fe != 0) m_f = p_res;
          m_c4 = p_c4; m_c8 = p_c8; m_v = p_v; m_z = p_res == 0 ? 1 : 0;
          m_done = 1; m_busy = 0;
        end
      end else if (valid) begin
        x_a = word[0] ? m_tmp[word[2:1]] : m_a;
        x_b = word[3] ? m_tmp[word[5:4]] : m_b;
        x_op = int'(word[9:6]);
        ref_op(x_op, x_a, x_b, int'(word[10]), p_res, p_c4, p_c8, p_v);
        p_de = int'(word[11]); p_dr = int'(word[13:12]); p_fe = int'(word[14]);
        m_left = x_op == 8 ? 9 : 1;
        m_busy = 1;
      end
      if (load) begin m_a = int'(din_a); m_b = int'(din_b); end
    end
  end

  always @(posedge clk) begin
    #2;
    if (armed) begin
      check("ready", 16'(ready), 16'(!m_busy && !rst));
      check("data_out", 16'(dout), 16'(m_f[7:0]));
      check("status", 16'(status), 16'({m_v[0], m_f == 0, m_z[0], m_c8[0], m_c4[0]}));
      check("done", 16'(done), 16'(m_done[0]));
    end
  end

  function automatic logic [14:0] mk(input logic as, input logic [1:0] ar, input logic bs,
                                     input logic [1:0] br, input logic [3:0] op, input logic cin,
                                     input logic de, input logic [1:0] dr, input logic fe);
    return {fe, dr, de, cin, op, br, bs, ar, as};
  endfunction

  task automatic ld(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); din_a = a; din_b = b; load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic issue(input logic [14:0] cw);
    int n = 0;
    word = cw; valid = 1'b1;
    while (!ready && n < 40) begin @(negedge clk); n++; end
    check("accept_in_time", 16'(n < 40), 16'd1);
    @(negedge clk); valid = 1'b0; word = 15'($urandom);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;
    bit seen;
    @(negedge clk);
    check("reset_ready_low", 16'(ready), 16'd0);
    @(negedge clk);
    check("reset_dout", 16'(dout), 16'h00);
    check("reset_status", 16'(status), 16'b01000);
    check("reset_done", 16'(done), 16'd0);
    rst = 1'b0;
    #1 check("ready_after_release", 16'(ready), 16'd1);
    @(negedge clk);
    ld(8'h7F, 8'h01);
    issue(mk(0, 0, 0, 0, 4'd0, 0, 0, 0, 1));
    check("add_done_early", 16'(done), 16'd0);
    @(negedge clk);
    check("add_done", 16'(done), 16'd1);
    check("add_dout", 16'(dout), 16'h80);
    check("add_status", 16'(status), 16'b10001);
    @(negedge clk);
    check("add_done_pulse", 16'(done), 16'd0);
    ld(8'h05, 8'h05);
    issue(mk(0, 0, 0, 0, 4'd1, 1, 1, 2, 0));
    din_a = 8'h00; din_b = 8'h03; load = 1'b1;
    word = mk(1, 2, 0, 0, 4'd0, 0, 0, 0, 1); valid = 1'b1;
    @(negedge clk); load = 1'b0;
    check("sub_status", 16'(status), 16'b00111);
    check("sub_f_kept", 16'(dout), 16'h80);
    check("sub_ready", 16'(ready), 16'd1);
    @(negedge clk); valid = 1'b0;
    check("chain_accepted", 16'(ready), 16'd0);
    @(negedge clk);
    check("chain_dout", 16'(dout), 16'h03);
    check("chain_status", 16'(status), 16'b00000);
    ld(8'h0C, 8'h15);
    issue(mk(0, 0, 0, 0, 4'd8, 0, 0, 0, 1));
    wait_ready(n);
    check("mul_busy_cycles", 16'(n), 16'd9);
    check("mul_done", 16'(done), 16'd1);
    check("mul_dout", 16'(dout), 16'hFC);
    check("mul_status", 16'(status), 16'b00000);
    ld(8'h10, 8'h10);
    issue(mk(0, 0, 0, 0, 4'd8, 0, 0, 0, 1));
    wait_ready(n);
    check("mul_ovf_dout", 16'(dout), 16'h00);
    check("mul_ovf_status", 16'(status), 16'b11110);
    ld(8'h5A, 8'h03);
    issue(mk(0, 0, 0, 0, 4'd5, 0, 1, 1, 1));
    wait_ready(n);
    check("pass_dout", 16'(dout), 16'h5A);
    issue(mk(0, 0, 0, 0, 4'd8, 0, 1, 3, 1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check("midrst_ready", 16'(ready), 16'd1);
    check("midrst_dout", 16'(dout), 16'h00);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= done; end
    check("midrst_no_done", 16'(seen), 16'd0);
    issue(mk(1, 1, 0, 0, 4'd5, 0, 0, 0, 1));
    wait_ready(n);
    check("midrst_temp_cleared", 16'(status), 16'b01100);
    ld(8'h11, 8'h00);
    din_a = 8'h22; load = 1'b1;
    word = mk(0, 0, 0, 0, 4'd5, 0, 0, 0, 1); valid = 1'b1;
    @(negedge clk); load = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("load_accept_old", 16'(dout), 16'h11);
    issue(mk(0, 0, 0, 0, 4'd5, 0, 0, 0, 1));
    @(negedge clk);
    check("load_accept_new", 16'(dout), 16'h22);
    repeat (800) begin
      @(negedge clk);
      rst = $urandom_range(0, 99) == 0;
      load = $urandom_range(0, 3) == 0;
      din_a = 8'($urandom);
      din_b = 8'($urandom);
      valid = $urandom_range(0, 9) < 7;
      w = 15'($urandom);
      if ($urandom_range(0, 3) == 0) w[9:6] = 4'd8;
      word = w;
    end
    @(negedge clk); rst = 1'b0; valid = 1'b0; load = 1'b0;
    repeat (12) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
